// File: rtl/mem_load_unit.sv
// Load unit: byte/half/word loads from a word-wide data memory with sign/zero extension.
// Optional MISALIGNED_LOAD_EN: word-crossing loads take two reads instead of faulting.
module mem_load_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_width,
    input  logic        req_unsigned,
    output logic        mem_rd_en,
    output logic [29:0] mem_rd_idx,
    input  logic [31:0] mem_rd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_fault
);

    localparam int unsigned IDX_W = 30;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;
    localparam logic [1:0] W_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        CAP0 = 3'd2,
`ifdef MISALIGNED_LOAD_EN
        CAP1 = 3'd4,
`endif
        RSP  = 3'd3
    } state_t;

    state_t            state_q, state_n;
    logic [1:0]        off_q;
    logic [1:0]        width_q;
    logic              uns_q;
    logic              accept_c;
    logic              req_fault_c;
    logic              crossing_c;

    logic              req_ready_n;
    logic              mem_rd_en_n;
    logic [IDX_W-1:0]  mem_rd_idx_n;
    logic              rsp_valid_n;
    logic [31:0]       rsp_data_n;
    logic              rsp_fault_n;

`ifdef MISALIGNED_LOAD_EN
    logic [31:0]       lo_q, lo_n;
`endif

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return a[31:2] % IDX_W'(MEM_WORDS);
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(MEM_WORDS - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Little-endian pick from {hi,lo} starting at the byte offset, then extend.
    function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] off,
                                            input logic [1:0] w, input logic u);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (w)
            W_BYTE:  return u ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            W_HALF:  return u ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign accept_c = req_valid && req_ready;

`ifdef MISALIGNED_LOAD_EN
    assign req_fault_c = (req_width == W_RSVD);
    assign crossing_c  = ((width_q == W_WORD) && (off_q != 2'b00)) ||
                         ((width_q == W_HALF) && (off_q == 2'b11));
`else
    assign req_fault_c = (req_width == W_RSVD) ||
                         ((req_width == W_HALF) && req_addr[0]) ||
                         ((req_width == W_WORD) && (req_addr[1:0] != 2'b00));
    assign crossing_c  = 1'b0;
`endif

    // Next state and next values of every registered output.
    always_comb begin
        state_n      = state_q;
        req_ready_n  = req_ready;
        mem_rd_en_n  = 1'b0;
        mem_rd_idx_n = mem_rd_idx;
        rsp_valid_n  = rsp_valid;
        rsp_data_n   = rsp_data;
        rsp_fault_n  = rsp_fault;
`ifdef MISALIGNED_LOAD_EN
        lo_n         = lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    req_ready_n = 1'b0;
                    if (req_fault_c) begin
                        state_n     = RSP;
                        rsp_valid_n = 1'b1;
                        rsp_fault_n = 1'b1;
                        rsp_data_n  = 32'h0;
                    end else begin
                        state_n      = REQ0;
                        mem_rd_en_n  = 1'b1;
                        mem_rd_idx_n = word_idx(req_addr);
                    end
                end
            end
            REQ0: begin
                state_n = CAP0;
                // Second read is strobed during CAP0 for word-crossing accesses.
                if (crossing_c) begin
                    mem_rd_en_n  = 1'b1;
                    mem_rd_idx_n = next_idx(mem_rd_idx);
                end
            end
            CAP0: begin
`ifdef MISALIGNED_LOAD_EN
                lo_n = mem_rd_data;
                if (crossing_c) begin
                    state_n = CAP1;
                end else begin
                    state_n     = RSP;
                    rsp_valid_n = 1'b1;
                    rsp_fault_n = 1'b0;
                    rsp_data_n  = extract({32'h0, mem_rd_data}, off_q, width_q, uns_q);
                end
`else
                state_n     = RSP;
                rsp_valid_n = 1'b1;
                rsp_fault_n = 1'b0;
                rsp_data_n  = extract({32'h0, mem_rd_data}, off_q, width_q, uns_q);
`endif
            end
`ifdef MISALIGNED_LOAD_EN
            CAP1: begin
                state_n     = RSP;
                rsp_valid_n = 1'b1;
                rsp_fault_n = 1'b0;
                rsp_data_n  = extract({mem_rd_data, lo_q}, off_q, width_q, uns_q);
            end
`endif
            RSP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                end
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

    // State, request fields and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            off_q      <= 2'b00;
            width_q    <= 2'b00;
            uns_q      <= 1'b0;
            req_ready  <= 1'b1;
            mem_rd_en  <= 1'b0;
            mem_rd_idx <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 32'h0;
            rsp_fault  <= 1'b0;
`ifdef MISALIGNED_LOAD_EN
            lo_q       <= 32'h0;
`endif
        end else begin
            state_q    <= state_n;
            req_ready  <= req_ready_n;
            mem_rd_en  <= mem_rd_en_n;
            mem_rd_idx <= mem_rd_idx_n;
            rsp_valid  <= rsp_valid_n;
            rsp_data   <= rsp_data_n;
            rsp_fault  <= rsp_fault_n;
`ifdef MISALIGNED_LOAD_EN
            lo_q       <= lo_n;
`endif
            if (accept_c) begin
                off_q   <= req_addr[1:0];
                width_q <= req_width;
                uns_q   <= req_unsigned;
            end
        end
    end

endmodule

// File: tb/tb_mem_load_unit.sv
// Randomized self-checking bench for mem_load_unit against a byte-addressed load model.
// Expectations follow MISALIGNED_LOAD_EN the same way the design is built.
module tb_mem_load_unit;

    localparam int unsigned MEM_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic        mem_rd_en;
    logic [29:0] mem_rd_idx;
    logic [31:0] mem_rd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_fault;

    logic [31:0] mem [MEM_WORDS];
    logic [29:0] rd_q [$];
    logic [31:0] last_data;
    logic        last_fault;
    int          n_checks = 0;
    int          n_pass   = 0;

    mem_load_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_width(req_width), .req_unsigned(req_unsigned),
        .mem_rd_en(mem_rd_en), .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;

    // Synchronous memory: data for a strobed index appears the following cycle.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_idx[7:0]];
            rd_q.push_back(mem_rd_idx);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[(a >> 2) % MEM_WORDS];
        return 8'(w >> (8 * a[1:0]));
    endfunction

    // Returns {fault, data} for a load, built byte by byte from the memory image.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [1:0] w, input logic u);
        int          nbytes;
        logic [31:0] v;
        if (w == 2'b11) return {1'b1, 32'h0};
        nbytes = 1 << w;
`ifndef MISALIGNED_LOAD_EN
        if ((a % nbytes) != 0) return {1'b1, 32'h0};
`endif
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v = v | (32'(byte_at(a + 32'(i))) << (8 * i));
        if (!u && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~((32'd1 << (8 * nbytes)) - 32'd1);
        return {1'b0, v};
    endfunction

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
    task automatic do_load(input logic [31:0] a, input logic [1:0] w, input logic u, input int hold);
        logic [32:0] m;
        bit          crossing;
        int          exp_lat, exp_reads, lat;
        int unsigned i0;
        m         = model(a, w, u);
        crossing  = (w == 2'b01 && a[1:0] == 2'b11) || (w == 2'b10 && a[1:0] != 2'b00);
        exp_lat   = m[32] ? 1 : (crossing ? 4 : 3);
        exp_reads = m[32] ? 0 : (crossing ? 2 : 1);
        i0        = (a >> 2) % MEM_WORDS;
        rd_q.delete();
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = a; req_width = w; req_unsigned = u;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            check_eq("req_ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("rsp_data", rsp_data, m[31:0]);
        check_eq("rsp_fault", 32'(rsp_fault), 32'(m[32]));
        last_data  = rsp_data;
        last_fault = rsp_fault;
        check_eq("n_reads", 32'(rd_q.size()), 32'(exp_reads));
        if (rd_q.size() >= 1 && exp_reads >= 1) check_eq("idx0", 32'(rd_q[0]), 32'(i0));
        if (rd_q.size() >= 2 && exp_reads >= 2) check_eq("idx1", 32'(rd_q[1]), 32'((i0 + 1) % MEM_WORDS));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_data", rsp_data, m[31:0]);
            check_eq("hold_fault", 32'(rsp_fault), 32'(m[32]));
            check_eq("hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_ready", 32'(req_ready), 32'd1);
        check_eq("extra_reads", 32'(rd_q.size()), 32'(exp_reads));
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
        mem[0] = 32'h44332211;
        mem[1] = 32'h88776655;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_width = '0;
        req_unsigned = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst_mem_rd_idx", 32'(mem_rd_idx), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_data", rsp_data, 32'd0);
        check_eq("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_load(32'h0, 2'b10, 1'b0, 0);
        check_eq("lw0_lit", last_data, 32'h44332211);
        do_load(32'h7, 2'b00, 1'b0, 1);
        check_eq("lb7_lit", last_data, 32'hFFFFFF88);
        do_load(32'h7, 2'b00, 1'b1, 0);
        check_eq("lbu7_lit", last_data, 32'h00000088);
        do_load(32'h2, 2'b01, 1'b0, 0);
        check_eq("lh2_lit", last_data, 32'h00004433);
        do_load(32'h1, 2'b10, 1'b0, 5);
`ifdef MISALIGNED_LOAD_EN
        check_eq("lw1_lit", last_data, 32'h55443322);
        check_eq("lw1_fault", 32'(last_fault), 32'd0);
`else
        check_eq("lw1_lit", last_data, 32'h0);
        check_eq("lw1_fault", 32'(last_fault), 32'd1);
`endif
        do_load(32'h3FF, 2'b01, 1'b0, 0);
        do_load(32'h3FF, 2'b01, 1'b1, 0);
        do_load(32'h10, 2'b11, 1'b1, 2);
        check_eq("rsvd_fault", 32'(last_fault), 32'd1);

        // Reset while the first read is being captured drops the transaction.
        req_valid = 1'b1; req_addr = 32'h4; req_width = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("cap0_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("cap0_rst_ready", 32'(req_ready), 32'd1);
        check_eq("cap0_rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("cap0_rst_idx", 32'(mem_rd_idx), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("cap0_rst_quiet", 32'(rsp_valid), 32'd0);
        end

        // Reset wins over a simultaneous request.
        rst = 1'b1; req_valid = 1'b1; req_addr = 32'h0; req_width = 2'b10;
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        check_eq("rst_pri_ready", 32'(req_ready), 32'd1);
        check_eq("rst_pri_rd_en", 32'(mem_rd_en), 32'd0);
        @(negedge clk);
        check_eq("rst_pri_rd_en2", 32'(mem_rd_en), 32'd0);
        check_eq("rst_pri_valid", 32'(rsp_valid), 32'd0);

        for (int n = 0; n < 200; n++) begin
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_load(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_load_unit.md
MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256: number of 32-bit words; word index wraps modulo MEM_WORDS.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: load request present.
REQ-005 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-006 SHALL have port req_addr, input, 32: byte address.
REQ-007 SHALL have port req_width, input, 2: 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned, input, 1: 1 zero-extends, 0 sign-extends.
REQ-009 SHALL have port mem_rd_en, output, 1: word read strobe to data memory.
REQ-010 SHALL have port mem_rd_idx, output, 30: word index; (addr[31:2]) mod MEM_WORDS.
REQ-011 SHALL have port mem_rd_data, input, 32: read word, valid the cycle after mem_rd_en.
REQ-012 SHALL have port rsp_valid, output, 1: response present.
REQ-013 SHALL have port rsp_ready, input, 1: consumer accepts response.
REQ-014 SHALL have port rsp_data, output, 32: extended load result.
REQ-015 SHALL have port rsp_fault, output, 1: request rejected (reserved width or disallowed misalignment).

Function
REQ-016 SHALL implement FSM IDLE -> REQ0 -> CAP0 -> [CAP1] -> RSP -> IDLE.
REQ-017 SHALL assert req_ready only in IDLE; accept on req_valid&&req_ready, latching addr, width, unsigned.
REQ-018 SHALL, in REQ0, drive mem_rd_en=1 with idx0=addr[31:2] mod MEM_WORDS.
REQ-019 SHALL, in CAP0, capture lo word; if access crosses a word boundary (word at offset 1-3, half at offset 3), drive mem_rd_en=1 with idx1=(idx0+1) mod MEM_WORDS and go to CAP1, else go to RSP.
REQ-020 SHALL, in CAP1, capture hi word and go to RSP.
REQ-021 SHALL assemble data little-endian as {hi,lo} shifted right by 8*addr[1:0]; take low 8/16/32 bits per width.
REQ-022 SHALL sign- or zero-extend byte/half per req_unsigned; ignore req_unsigned for word.
REQ-023 SHALL hold rsp_valid, rsp_data, rsp_fault stable in RSP until rsp_ready=1, then return to IDLE next cycle.
REQ-024 SHALL give latency accept-to-rsp_valid of 3 cycles non-crossing, 4 crossing.
REQ-025 SHALL, for width 11, issue no memory read, go IDLE -> RSP directly (rsp_valid 1 cycle after accept), rsp_fault=1, rsp_data=0.
REQ-026 SHALL keep mem_rd_en=0 outside REQ0 and the crossing cycle of CAP0.

Reset
REQ-027 SHALL, on rst, enter IDLE, drop any in-flight transaction, and drive req_ready=1, mem_rd_en=0, mem_rd_idx=0, rsp_valid=0, rsp_data=0, rsp_fault=0 from the next cycle.
REQ-028 SHALL give rst priority over a simultaneous request or rsp_ready.

Configuration
REQ-029 SHALL, with MISALIGNED_LOAD_EN defined, service word-crossing accesses with two reads per REQ-019.
REQ-030 SHALL, without MISALIGNED_LOAD_EN, treat any address not aligned to its width as a fault: no memory read, IDLE -> RSP, rsp_fault=1, rsp_data=0; CAP1 is not built.

Verification (memory word0=0x44332211, word1=0x88776655)
REQ-031 SHALL check: lw addr 0x0 accepted at T -> rsp_valid at T+3, rsp_data 0x44332211, fault 0.
REQ-032 SHALL check: lb addr 0x7 signed -> 0xFFFFFF88; lbu addr 0x7 -> 0x00000088; lh addr 0x2 signed -> 0x00004433.
REQ-033 SHALL check: lw addr 0x1 with macro -> reads idx 0 then 1, rsp at T+4 = 0x55443322; without macro -> fault 1, data 0, no mem_rd_en.
REQ-034 SHALL check: MEM_WORDS=256, lh addr 0x3FF with macro -> reads idx 255 then idx 0 (wrap), data = {word0[7:0], word255[31:24]} extended.
REQ-035 SHALL check: rsp_ready held 0 for 5 cycles -> rsp_data stable, req_ready 0; rst asserted in CAP0 -> next cycle rsp_valid 0, req_ready 1, no response emitted.
